data_ram_ctrl: RTL

//  Parametrised synchronous data RAM with a ready/valid request/response interface.

---
 rtl/data_ram_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl: single-outstanding load/store RAM with byte lanes, extension and range/alignment checks.
// Optional RAM_CLEAR_EN: zero every word after reset before accepting requests.
module data_ram_ctrl #(
    parameter int          DWIDTH    = 32,
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err
);
    localparam int NB = DWIDTH / 8;
    localparam int LB = $clog2(NB);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = $clog2(DWIDTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * NB);

    typedef enum logic [1:0] {IDLE, RESP, CLEAR} state_t;

    state_t            state, state_n;
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [31:0]       offset;
    logic [AW-1:0]     idx;
    logic [LB-1:0]     lane;
    logic              err, accept;
    logic [DWIDTH-1:0] word, shifted, mask, ext, wshift;
    logic [NB-1:0]     be;
    logic [6:0]        bits;
    logic [SW-1:0]     sidx;
`ifdef RAM_CLEAR_EN
    logic [AW-1:0]     cidx;
`endif

    // Request decode: wrap-around subtraction makes addresses below the base fall out of range too.
    always_comb begin
        offset  = req_addr - BASE_ADDR;
        idx     = offset[LB +: AW];
        lane    = offset[LB-1:0];
        err     = (offset >= SPAN) | (req_size == 2'b01 & req_addr[0]) |
                  (req_size == 2'b10 & |req_addr[1:0]) |
                  (req_size == 2'b11 & (DWIDTH == 32 | |req_addr[2:0]));
        bits    = 7'd8 << req_size;
        sidx    = SW'(bits - 7'd1);
        word    = mem[idx];
        shifted = word >> {lane, 3'b000};
        mask    = ~({DWIDTH{1'b1}} << bits);
        ext     = (shifted & mask) | ((~req_unsigned & shifted[sidx]) ? ~mask : '0);
        wshift  = req_wdata << {lane, 3'b000};
        be      = NB'(~({NB{1'b1}} << (4'd1 << req_size))) << lane;
    end

    assign req_ready = nreset & (state == IDLE | (state == RESP & rsp_ready));
    assign rsp_valid = state == RESP;
    assign accept    = req_valid & req_ready;

    // Next state: a fresh accept always leads to RESP, even while draining the previous response.
    always_comb begin
        state_n = accept ? RESP : (state == RESP & rsp_ready) ? IDLE : state;
`ifdef RAM_CLEAR_EN
        if (state == CLEAR)
            state_n = (cidx == AW'(DEPTH - 1)) ? IDLE : CLEAR;
`endif
    end

    // State and response registers; reset drops any pending response at once.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
`ifdef RAM_CLEAR_EN
            state <= CLEAR;
`else
            state <= IDLE;
`endif
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                rsp_rdata <= (err | req_we) ? '0 : ext;
                rsp_err   <= err;
            end else if (state == RESP & rsp_ready) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end
        end
    end

`ifdef RAM_CLEAR_EN
    // Clear pointer walks the words once per reset.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset)
            cidx <= '0;
        else if (state == CLEAR)
            cidx <= cidx + 1'b1;
    end
`endif

    // Memory writes: clearing has priority, otherwise only the addressed lanes of a legal store.
    always_ff @(posedge clock) begin
`ifdef RAM_CLEAR_EN
        if (state == CLEAR)
            mem[cidx] <= '0;
        else
`endif
        if (accept & req_we & ~err)
            for (int j = 0; j < NB; j++)
                if (be[j])
                    mem[idx][j*8 +: 8] <= wshift[j*8 +: 8];
    end
endmodule
